game_flow_controller: RTL and testbench

Parametrised successor to the game state master. It sequences title screen, countdown, in-game, pause, time-out and highscore states, and selects 1..MAX_PLAYERS players. It also owns the round timer and start countdown, both driven by an external tick strobe. It sits between the debounced button inputs and the display/gameplay blocks and drives their mode flags.

---
 rtl/game_flow_controller.sv | 157 +++++++++++++++
 tb/tb_game_flow_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Game flow sequencer: title/countdown/in-game/pause/time-out/highscore states,
// player selection, and the tick-driven round timer and start countdown.
module game_flow_controller #(
    parameter int MAX_PLAYERS     = 4,
    parameter int PW              = 2,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 60,
    parameter int TW              = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          up,
    input  logic          down,
    input  logic          pause,
    input  logic          restart,
    input  logic          tick,
    input  logic          new_record,
    output logic [PW-1:0] player_count,
    output logic [2:0]    state_code,
    output logic          title_screen,
    output logic          countdown,
    output logic          game_on,
    output logic          paused,
    output logic          time_out,
    output logic          highscore,
    output logic [TW-1:0] round_time,
    output logic [TW-1:0] countdown_val
);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_IN_GAME   = 3'd2,
        S_PAUSED    = 3'd3,
        S_TIME_OUT  = 3'd4,
        S_HIGHSCORE = 3'd5
    } state_t;

    localparam logic [TW-1:0] CD_LOAD    = TW'(COUNTDOWN_TICKS);
    localparam logic [TW-1:0] ROUND_LOAD = TW'(ROUND_TICKS);
    localparam logic [TW-1:0] ONE        = TW'(1);
    localparam logic [PW-1:0] PC_MAX     = PW'(MAX_PLAYERS - 1);
    localparam logic [PW-1:0] PC_ONE     = PW'(1);

    state_t state, next_state;
    logic   start_q, up_q, down_q, pause_q, restart_q;
    logic   start_rise, up_rise, down_rise, pause_rise, restart_rise;
    logic   record;
    logic   enter_cd;

    assign start_rise   = start   & ~start_q;
    assign up_rise      = up      & ~up_q;
    assign down_rise    = down    & ~down_q;
    assign pause_rise   = pause   & ~pause_q;
    assign restart_rise = restart & ~restart_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            start_q   <= start;
            up_q      <= up;
            down_q    <= down;
            pause_q   <= pause;
            restart_q <= restart;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_TITLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_TITLE:     if (start_rise) next_state = S_COUNTDOWN;
            // A zero countdown load falls straight through to play.
            S_COUNTDOWN: if (countdown_val == '0 || (tick && countdown_val == ONE))
                             next_state = S_IN_GAME;
            S_IN_GAME: begin
                if (tick && round_time == ONE) next_state = S_TIME_OUT;
                else if (pause_rise)           next_state = S_PAUSED;
            end
            S_PAUSED: begin
                if (pause_rise)      next_state = S_IN_GAME;
                else if (start_rise) next_state = S_TITLE;
            end
            S_TIME_OUT: begin
                if (restart_rise)    next_state = S_COUNTDOWN;
                else if (start_rise) next_state = record ? S_HIGHSCORE : S_TITLE;
            end
            S_HIGHSCORE: if (start_rise || restart_rise) next_state = S_TITLE;
            default:     next_state = S_TITLE;
        endcase
    end

    assign enter_cd = (next_state == S_COUNTDOWN) && (state != S_COUNTDOWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            countdown_val <= CD_LOAD;
            round_time    <= ROUND_LOAD;
            record        <= 1'b0;
        end else if (enter_cd) begin
            countdown_val <= CD_LOAD;
            round_time    <= ROUND_LOAD;
            record        <= 1'b0;
        end else begin
            if (state == S_COUNTDOWN && tick && countdown_val != '0)
                countdown_val <= countdown_val - ONE;
            if (state == S_IN_GAME && tick && round_time != '0)
                round_time <= round_time - ONE;
            if (new_record && (state == S_IN_GAME || state == S_PAUSED || state == S_TIME_OUT))
                record <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            player_count <= '0;
        end else if (state == S_TITLE) begin
            if (down_rise && !up_rise && player_count != PC_MAX)
                player_count <= player_count + PC_ONE;
            else if (up_rise && !down_rise && player_count != '0)
                player_count <= player_count - PC_ONE;
        end
    end

    always_comb begin
        state_code   = state;
        title_screen = 1'b0;
        countdown    = 1'b0;
        game_on      = 1'b0;
        paused       = 1'b0;
        time_out     = 1'b0;
        highscore    = 1'b0;
        case (state)
            S_TITLE:     title_screen = 1'b1;
            S_COUNTDOWN: countdown    = 1'b1;
            S_IN_GAME:   game_on      = 1'b1;
            S_PAUSED: begin
                game_on = 1'b1;
                paused  = 1'b1;
            end
            S_TIME_OUT:  time_out     = 1'b1;
            S_HIGHSCORE: highscore    = 1'b1;
            default:     state_code   = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed testbench for game_flow_controller: default build plus a zero-countdown build.
module tb_game_flow_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, up = 1'b0, down = 1'b0, pause = 1'b0, restart = 1'b0;
    logic tick = 1'b0, new_record = 1'b0;

    logic [1:0] pc;
    logic [2:0] sc;
    logic       f_title, f_cd, f_game, f_paused, f_to, f_hs;
    logic [7:0] rtime, cval;

    logic [1:0] pc1;
    logic [2:0] sc1;
    logic       g_title, g_cd, g_game, g_paused, g_to, g_hs;
    logic [7:0] rtime1, cval1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    game_flow_controller #(.MAX_PLAYERS(4), .PW(2), .COUNTDOWN_TICKS(3), .ROUND_TICKS(60), .TW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .pause(pause),
        .restart(restart), .tick(tick), .new_record(new_record),
        .player_count(pc), .state_code(sc), .title_screen(f_title), .countdown(f_cd),
        .game_on(f_game), .paused(f_paused), .time_out(f_to), .highscore(f_hs),
        .round_time(rtime), .countdown_val(cval)
    );

    game_flow_controller #(.MAX_PLAYERS(4), .PW(2), .COUNTDOWN_TICKS(0), .ROUND_TICKS(60), .TW(8)) dut_cd0 (
        .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .pause(pause),
        .restart(restart), .tick(tick), .new_record(new_record),
        .player_count(pc1), .state_code(sc1), .title_screen(g_title), .countdown(g_cd),
        .game_on(g_game), .paused(g_paused), .time_out(g_to), .highscore(g_hs),
        .round_time(rtime1), .countdown_val(cval1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({f_title, f_cd, f_game, f_paused, f_to, f_hs} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags got=%b exp=100000", {f_title, f_cd, f_game, f_paused, f_to, f_hs});
        end
        vectors++;
        if (pc !== 2'd0 || rtime !== 8'd60 || cval !== 8'd3 || sc !== 3'd0) begin
            errors++; $display("FAIL reset_values got pc=%0d rt=%0d cv=%0d sc=%0d exp pc=0 rt=60 cv=3 sc=0", pc, rtime, cval, sc);
        end
    endtask

    task automatic test_player_select();
        logic [1:0] exp_pc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            down = 1'b1;
            step();
            vectors++;
            if (pc !== exp_pc[i]) begin
                errors++; $display("FAIL down_pulse_%0d got=%0d exp=%0d", i, pc, exp_pc[i]);
            end
            down = 1'b0;
            step();
        end
        up = 1'b1;
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (pc !== 2'd2) begin
            errors++; $display("FAIL up_held got=%0d exp=2", pc);
        end
        up = 1'b0;
        step();
        up = 1'b1;
        down = 1'b1;
        step();
        vectors++;
        if (pc !== 2'd2) begin
            errors++; $display("FAIL up_down_same got=%0d exp=2", pc);
        end
        up = 1'b0;
        down = 1'b0;
        step();
    endtask

    task automatic test_countdown_and_round();
        logic [7:0] exp_cv [3] = '{8'd2, 8'd1, 8'd0};
        start = 1'b1;
        step();
        vectors++;
        if (f_cd !== 1'b1 || sc !== 3'd1 || cval !== 8'd3 || rtime !== 8'd60) begin
            errors++; $display("FAIL enter_countdown got cd=%b sc=%0d cv=%0d rt=%0d exp cd=1 sc=1 cv=3 rt=60", f_cd, sc, cval, rtime);
        end
        start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            vectors++;
            if (cval !== exp_cv[i] || f_cd !== (i < 2) || f_game !== (i == 2)) begin
                errors++; $display("FAIL countdown_tick_%0d got cv=%0d cd=%b go=%b exp cv=%0d cd=%b go=%b",
                                   i, cval, f_cd, f_game, exp_cv[i], (i < 2), (i == 2));
            end
        end
        tick_n(59);
        vectors++;
        if (rtime !== 8'd1 || f_game !== 1'b1) begin
            errors++; $display("FAIL round_59 got rt=%0d go=%b exp rt=1 go=1", rtime, f_game);
        end
        tick_n(1);
        vectors++;
        if (rtime !== 8'd0 || f_to !== 1'b1 || f_game !== 1'b0 || sc !== 3'd4) begin
            errors++; $display("FAIL round_expiry got rt=%0d to=%b go=%b sc=%0d exp rt=0 to=1 go=0 sc=4", rtime, f_to, f_game, sc);
        end
        tick_n(2);
        vectors++;
        if (rtime !== 8'd0 || f_to !== 1'b1) begin
            errors++; $display("FAIL no_underflow got rt=%0d to=%b exp rt=0 to=1", rtime, f_to);
        end
    endtask

    task automatic test_pause();
        restart = 1'b1;
        step();
        vectors++;
        if (sc !== 3'd1 || rtime !== 8'd60 || cval !== 8'd3) begin
            errors++; $display("FAIL restart_reload got sc=%0d rt=%0d cv=%0d exp sc=1 rt=60 cv=3", sc, rtime, cval);
        end
        restart = 1'b0;
        step();
        tick_n(3);
        tick_n(50);
        vectors++;
        if (rtime !== 8'd10 || sc !== 3'd2) begin
            errors++; $display("FAIL round_at_10 got rt=%0d sc=%0d exp rt=10 sc=2", rtime, sc);
        end
        pause = 1'b1;
        step();
        vectors++;
        if (f_paused !== 1'b1 || f_game !== 1'b1 || sc !== 3'd3) begin
            errors++; $display("FAIL pause_enter got p=%b go=%b sc=%0d exp p=1 go=1 sc=3", f_paused, f_game, sc);
        end
        pause = 1'b0;
        step();
        tick_n(5);
        vectors++;
        if (rtime !== 8'd10 || f_paused !== 1'b1) begin
            errors++; $display("FAIL paused_hold got rt=%0d p=%b exp rt=10 p=1", rtime, f_paused);
        end
        pause = 1'b1;
        step();
        vectors++;
        if (sc !== 3'd2 || f_paused !== 1'b0) begin
            errors++; $display("FAIL pause_exit got sc=%0d p=%b exp sc=2 p=0", sc, f_paused);
        end
        pause = 1'b0;
        step();
        pause = 1'b1;
        tick = 1'b1;
        step();
        vectors++;
        if (rtime !== 8'd9 || sc !== 3'd3) begin
            errors++; $display("FAIL pause_with_tick got rt=%0d sc=%0d exp rt=9 sc=3", rtime, sc);
        end
        pause = 1'b0;
        tick = 1'b0;
        step();
    endtask

    task automatic test_record();
        pause = 1'b1;
        step();
        pause = 1'b0;
        step();
        new_record = 1'b1;
        step();
        new_record = 1'b0;
        tick_n(9);
        vectors++;
        if (sc !== 3'd4 || rtime !== 8'd0) begin
            errors++; $display("FAIL record_expiry got sc=%0d rt=%0d exp sc=4 rt=0", sc, rtime);
        end
        start = 1'b1;
        restart = 1'b1;
        step();
        vectors++;
        if (sc !== 3'd1 || rtime !== 8'd60 || cval !== 8'd3) begin
            errors++; $display("FAIL restart_priority got sc=%0d rt=%0d cv=%0d exp sc=1 rt=60 cv=3", sc, rtime, cval);
        end
        start = 1'b0;
        restart = 1'b0;
        step();
        tick_n(63);
        start = 1'b1;
        step();
        vectors++;
        if (f_title !== 1'b1 || f_hs !== 1'b0) begin
            errors++; $display("FAIL latch_cleared got title=%b hs=%b exp title=1 hs=0", f_title, f_hs);
        end
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tick_n(3);
        new_record = 1'b1;
        step();
        new_record = 1'b0;
        tick_n(60);
        start = 1'b1;
        step();
        vectors++;
        if (f_hs !== 1'b1 || sc !== 3'd5) begin
            errors++; $display("FAIL highscore_enter got hs=%b sc=%0d exp hs=1 sc=5", f_hs, sc);
        end
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        vectors++;
        if (f_title !== 1'b1 || pc !== 2'd2) begin
            errors++; $display("FAIL highscore_exit got title=%b pc=%0d exp title=1 pc=2", f_title, pc);
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_game();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tick_n(8);
        vectors++;
        if (rtime !== 8'd55 || sc !== 3'd2) begin
            errors++; $display("FAIL pre_reset_round got rt=%0d sc=%0d exp rt=55 sc=2", rtime, sc);
        end
        rst = 1'b1;
        tick = 1'b1;
        step();
        vectors++;
        if (f_title !== 1'b1 || rtime !== 8'd60 || pc !== 2'd0 || cval !== 8'd3 || f_game !== 1'b0) begin
            errors++; $display("FAIL mid_game_reset got title=%b rt=%0d pc=%0d cv=%0d go=%b exp title=1 rt=60 pc=0 cv=3 go=0",
                               f_title, rtime, pc, cval, f_game);
        end
        rst = 1'b0;
        tick = 1'b0;
        step();
    endtask

    task automatic test_zero_countdown();
        start = 1'b1;
        step();
        vectors++;
        if (sc1 !== 3'd1 || cval1 !== 8'd0) begin
            errors++; $display("FAIL cd0_enter got sc=%0d cv=%0d exp sc=1 cv=0", sc1, cval1);
        end
        start = 1'b0;
        step();
        vectors++;
        if (sc1 !== 3'd2 || g_game !== 1'b1 || rtime1 !== 8'd60) begin
            errors++; $display("FAIL cd0_play got sc=%0d go=%b rt=%0d exp sc=2 go=1 rt=60", sc1, g_game, rtime1);
        end
    endtask

    initial begin
        test_reset();
        test_player_select();
        test_countdown_and_round();
        test_pause();
        test_record();
        test_reset_mid_game();
        test_zero_countdown();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
